// File: rtl/duzen_min_pkg.sv
// Shared definitions for the chronometer digit stages: control states,
// default digit limits and the seven-segment lookup table.
package duzen_min_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      ADJUST = 2'd1,
      SETTLE = 2'd2
   } state_e;

   localparam int MAX_DIGIT_DEFAULT = 5;
   localparam int WIDTH_DEFAULT     = 3;

   // Segment order {g,f,e,d,c,b,a}; entry k is the pattern for digit k
   localparam logic [9:0][6:0] SEG7_TABLE = {
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };
   localparam logic [6:0] SEG7_BLANK = 7'h00;

   function automatic logic [6:0] seg7_of(input logic [3:0] digit);
      if (digit > 4'd9) begin
         return SEG7_BLANK;
      end
      return SEG7_TABLE[digit];
   endfunction

endpackage

// File: rtl/duzen_min_seg7.sv
// Combinational digit-to-segment decoder; values above MAX_DIGIT blank
// the display. MAX_DIGIT is expected to be at most 9.
module duzen_min_seg7
   import duzen_min_pkg::*;
#(
   parameter int WIDTH     = WIDTH_DEFAULT,
   parameter int MAX_DIGIT = MAX_DIGIT_DEFAULT
) (
   input  logic [WIDTH-1:0] digit_i,
   output logic [6:0]       seg_o
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_DIGIT);

   always_comb begin
      seg_o = SEG7_BLANK;
      if (digit_i <= MAX_V) begin
         seg_o = seg7_of(4'(digit_i));
      end
   end

endmodule

// File: rtl/duzen_min_digit_reg.sv
// Tens-of-minutes digit register: counts on the units-minute carry in run
// mode, takes per-bit SET/RST excitation while adjusting, drives segments.
module duzen_min_digit_reg
   import duzen_min_pkg::*;
#(
   parameter int MAX_DIGIT = MAX_DIGIT_DEFAULT,
   parameter int WIDTH     = WIDTH_DEFAULT
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             EN,
   input  logic             ADJ,
   input  logic [WIDTH-1:0] SET,
   input  logic [WIDTH-1:0] RST,
   input  logic             ERR_CLR,
   output logic [WIDTH-1:0] Q,
   output logic             CARRY,
   output logic [6:0]       SEG,
   output logic             ERR
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_DIGIT);
   localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [6:0]       seg_q, seg_d;
   logic             carry_q, carry_d;
   logic             err_q, err_d;
   logic             err_new;

   logic [WIDTH-1:0] sr_resolved;
   logic [WIDTH-1:0] sr_conflict;

   // Exactly one of SET/RST drives the bit to SET's value; none or both hold it
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_sr
      assign sr_resolved[gi] = (SET[gi] ^ RST[gi]) ? SET[gi] : q_q[gi];
      assign sr_conflict[gi] = SET[gi] & RST[gi];
   end

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      carry_d = 1'b0;
      err_new = 1'b0;
      case (state_q)
         RUN: begin
            if (ADJ) begin
               state_d = ADJUST;
            end else if (EN) begin
               if (q_q == MAX_V) begin
                  q_d     = '0;
                  carry_d = 1'b1;
               end else begin
                  q_d = q_q + ONE_V;
               end
            end
         end
         ADJUST: begin
            if (!ADJ) begin
               state_d = SETTLE;
            end
            err_new = |sr_conflict;
            if (sr_resolved > MAX_V) begin
               q_d     = '0;
               err_new = 1'b1;
            end else begin
               q_d = sr_resolved;
            end
         end
         SETTLE: begin
            state_d = ADJ ? ADJUST : RUN;
         end
         default: begin
            state_d = RUN;
         end
      endcase
      // A fresh error outranks a clear request on the same cycle
      err_d = err_new | (err_q & ~ERR_CLR);
   end

   // Decoding next-Q lets the segment register land on the same edge as Q
   duzen_min_seg7 #(
      .WIDTH     (WIDTH),
      .MAX_DIGIT (MAX_DIGIT)
   ) u_seg7 (
      .digit_i (q_d),
      .seg_o   (seg_d)
   );

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= RUN;
         q_q     <= '0;
         seg_q   <= SEG7_TABLE[0];
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         seg_q   <= seg_d;
         carry_q <= carry_d;
         err_q   <= err_d;
      end
   end

   assign Q     = q_q;
   assign SEG   = seg_q;
   assign CARRY = carry_q;
   assign ERR   = err_q;

endmodule
